// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with elaboration-time frame format.
// i_valid/o_ready/i_data feed a TX FIFO; o_tx, o_busy, o_fifo_count out.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CLKS_PER_BIT =
    (BAUD_RATE > 0) ? CLK_FREQ / BAUD_RATE : 0;

  localparam int TW =
    (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  localparam int AW =
    (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam int BW =
    (DATA_BITS < 5) ? 3 : $clog2(DATA_BITS);

  localparam bit PARAM_OK =
    (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
    (PARITY >= 0) && (PARITY <= 2) &&
    ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
    (FIFO_DEPTH >= 2) &&
    ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
    (BAUD_RATE > 0) &&
    (CLKS_PER_BIT >= 2);

  if (!PARAM_OK) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  // Serialiser
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 push;
  logic                 pop;
  logic                 tick;
  logic                 have_word;
  logic [DATA_BITS-1:0] head;

  assign o_ready      = count_q < CW'(FIFO_DEPTH);
  assign push         = i_valid && o_ready;
  assign have_word    = count_q != '0;
  assign head         = mem_q[rd_ptr_q];
  assign tick         = timer_q == TW'(CLKS_PER_BIT - 1);
  assign o_tx         = tx_q;
  assign o_fifo_count = count_q;
  assign o_busy       = have_word || (state_q != S_IDLE);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic. Every state change except IDLE->START
  // happens on a tick, where the timer wraps to zero anyway;
  // IDLE holds the timer at zero, so each state starts fresh.
  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (have_word) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 2);
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Zero-gap chaining: load the next word straight
            // into a start bit when one is waiting.
            if (have_word) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ (PARITY == 2);
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Line level follows the state being entered, so the
  // registered output lines up with the state register.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four frame formats, each with a frame-level
// reference model and directed + random push traffic.
module tb_uart_tx_cfg;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int CF  = (g == 3) ? 25_000_000 : 400;
    localparam int BR  = (g == 3) ? 115_200 : 100;
    localparam int DB  = (g == 1) ? 7 : (g == 2) ? 9 : 8;
    localparam int PA  = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int SB  = (g == 1) ? 2 : 1;
    localparam int FD  = (g == 1) ? 2 : (g == 2) ? 8 : 4;
    localparam int CPB = CF / BR;
    localparam int FRAME =
      (1 + DB + ((PA != 0) ? 1 : 0) + SB) * CPB;
    localparam int LIM = FRAME * (FD + 4) + 100;
    localparam int BURST = (FD + 1 < 8) ? FD + 1 : 8;
    localparam logic [26:0] DW =
      (g == 0) ? {9'h0FF, 9'h000, 9'h0A5} :
      (g == 1) ? {9'h000, 9'h007, 9'h055} :
      (g == 2) ? {9'h000, 9'h007, 9'h1FF} :
                 {9'h081, 9'h05A, 9'h000};

    logic                  rst_n;
    logic                  valid;
    logic                  ready;
    logic [DB-1:0]         data;
    logic                  tx;
    logic                  busy;
    logic [$clog2(FD):0]   cnt;
    bit                    fin = 1'b0;

    uart_tx_cfg #(
      .CLK_FREQ  (CF),
      .BAUD_RATE (BR),
      .DATA_BITS (DB),
      .PARITY    (PA),
      .STOP_BITS (SB),
      .FIFO_DEPTH(FD)
    ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_data      (data),
      .o_tx        (tx),
      .o_busy      (busy),
      .o_fifo_count(cnt)
    );

    // Reference: a word queue and a queue of future line
    // levels, one entry per clock. A frame is expanded from
    // its word when the line has nothing left to send.
    logic [DB-1:0] mq [$];
    bit            lq [$];
    bit            emit   = 1'b0;
    logic          exp_tx = 1'b1;

    initial forever begin : model
      logic [DB-1:0] w;
      bit            p;
      bit            can;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        lq.delete();
        emit   = 1'b0;
        exp_tx = 1'b1;
      end else begin
        can = mq.size() < FD;
        if (lq.size() == 0 && mq.size() != 0) begin
          w = mq.pop_front();
          p = ^w;
          if (PA == 2) p = ~p;
          for (int r = 0; r < CPB; r++) lq.push_back(1'b0);
          for (int i = 0; i < DB; i++)
            for (int r = 0; r < CPB; r++) lq.push_back(w[i]);
          if (PA != 0)
            for (int r = 0; r < CPB; r++) lq.push_back(p);
          for (int r = 0; r < SB * CPB; r++) lq.push_back(1'b1);
        end
        if (valid && can) mq.push_back(data);
        if (lq.size() != 0) begin
          exp_tx = lq.pop_front();
          emit   = 1'b1;
        end else begin
          exp_tx = 1'b1;
          emit   = 1'b0;
        end
      end
    end

    initial forever begin : mon
      @(negedge clk);
      chk($sformatf("c%0d_tx", g), 32'(tx), 32'(exp_tx));
      chk($sformatf("c%0d_busy", g), 32'(busy),
          32'(emit || mq.size() != 0));
      chk($sformatf("c%0d_cnt", g), 32'(cnt), mq.size());
      chk($sformatf("c%0d_rdy", g), 32'(ready),
          32'(mq.size() < FD));
    end

    initial begin : stim
      int k;
      int acc;
      int nb;
      rst_n = 1'b1;
      valid = 1'b0;
      data  = '0;
      #1 rst_n = 1'b0;
      #1;
      chk($sformatf("c%0d_rst_tx", g), 32'(tx), 1);
      chk($sformatf("c%0d_rst_cnt", g), 32'(cnt), 0);
      chk($sformatf("c%0d_rst_busy", g), 32'(busy), 0);
      chk($sformatf("c%0d_rst_rdy", g), 32'(ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed words from idle, frame length measured.
      for (int i = 0; i < 3; i++) begin
        valid = 1'b1;
        data  = DB'(DW[i*9 +: 9]);
        k = 0;
        while (!ready && k < LIM) begin
          @(negedge clk);
          k++;
        end
        @(negedge clk);
        valid = 1'b0;
        k = 0;
        while (busy && k < LIM) begin
          @(negedge clk);
          k++;
        end
        chk($sformatf("c%0d_flen%0d", g, i), k, FRAME + 1);
        repeat (3) @(negedge clk);
      end

      // Hold valid for 8 cycles from idle.
      acc = 0;
      nb  = 0;
      for (int c = 0; c < 8; c++) begin
        valid = 1'b1;
        data  = DB'($urandom);
        if (ready) acc++;
        @(negedge clk);
        if (busy) nb++;
      end
      valid = 1'b0;
      k = 0;
      while (busy && k < LIM) begin
        @(negedge clk);
        k++;
        if (busy) nb++;
      end
      chk($sformatf("c%0d_burst", g), acc, BURST);
      chk($sformatf("c%0d_bbusy", g), nb, acc * FRAME + 1);

      // Random traffic.
      for (int c = 0; c < FRAME * 4; c++) begin
        valid = ($urandom_range(0, 2) == 0);
        data  = DB'($urandom);
        @(negedge clk);
      end
      valid = 1'b0;
      k = 0;
      while (busy && k < LIM) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("c%0d_drain", g), 32'(busy), 0);
      repeat (2) @(negedge clk);

      // Reset in the middle of data bit 3 with words queued.
      valid = 1'b1;
      data  = '0;
      repeat (3) @(negedge clk);
      valid = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      chk($sformatf("c%0d_pre_tx", g), 32'(tx), 0);
      chk($sformatf("c%0d_pre_cnt", g), 32'(cnt), 2);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("c%0d_ar_tx", g), 32'(tx), 1);
      chk($sformatf("c%0d_ar_cnt", g), 32'(cnt), 0);
      chk($sformatf("c%0d_ar_busy", g), 32'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nb = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        if (!tx || busy) nb++;
      end
      chk($sformatf("c%0d_post", g), nb, 0);
      fin = 1'b1;
    end
  end

  initial begin : top
    int k;
    bit all;
    k   = 0;
    all = 1'b0;
    while (!all && k < 90000) begin
      @(negedge clk);
      k++;
      all = cfg[0].fin && cfg[1].fin &&
            cfg[2].fin && cfg[3].fin;
    end
    chk("all_done", 32'(all), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
